// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID-stage operand/destination info in, pipeline enables/flushes/forward selects out.
interface pipe_hazard_ctrl_if #(parameter int REG_AW = 3);
    logic              id_valid, id_rs_en, id_rt_en, id_rd_en, id_is_load, id_is_halt;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic              redirect, mem_busy;
    logic              pc_en, ifid_en, idex_bubble, flush_ifid, flush_idex, halt_done, err;
    logic [1:0]        fwd_a, fwd_b;
    modport master (
        output id_valid, id_rs_en, id_rs, id_rt_en, id_rt, id_rd_en, id_rd, id_is_load, id_is_halt,
        output redirect, mem_busy,
        input  pc_en, ifid_en, idex_bubble, flush_ifid, flush_idex, fwd_a, fwd_b, halt_done, err
    );
    modport slave (
        input  id_valid, id_rs_en, id_rs, id_rt_en, id_rt, id_rd_en, id_rd, id_is_load, id_is_halt,
        input  redirect, mem_busy,
        output pc_en, ifid_en, idex_bubble, flush_ifid, flush_idex, fwd_a, fwd_b, halt_done, err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: EX/MEM/WB destination scoreboard driving stalls, bubbles, flushes, forwarding and HALT drain.
module pipe_hazard_ctrl #(
    parameter int REG_AW   = 3,
    parameter int SQUASH_N = 2
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic              valid;
        logic              rd_en;
        logic [REG_AW-1:0] rd;
        logic              is_halt;
    } slot_t;
    localparam logic SQ_BAD = (SQUASH_N < 1) || (SQUASH_N > 2);
    state_t     state, state_nxt;
    slot_t      ex, mem;
    logic       ex_load, wb_halt, pend, err_q;
    logic [1:0] fwd_a_q, fwd_b_q;
    logic       adv, redir, id_ok, lu, issue, halt2, go;

    function automatic logic [1:0] fwd_sel(logic en, logic [REG_AW-1:0] r, slot_t e, slot_t m);
        return !en ? 2'b00 : (e.valid && e.rd_en && e.rd == r) ? 2'b01 :
               (m.valid && m.rd_en && m.rd == r) ? 2'b10 : 2'b00;
    endfunction

    // a redirect seen during mem_busy is remembered in pend and applied on the next advancing cycle
    always_comb begin
        adv   = !hz.mem_busy;
        redir = adv && (hz.redirect || pend);
        id_ok = hz.id_valid && state == RUN;
        lu    = id_ok && ex.valid && ex_load && ex.rd_en &&
                ((hz.id_rs_en && hz.id_rs == ex.rd) || (hz.id_rt_en && hz.id_rt == ex.rd));
        issue = adv && id_ok && !lu && !redir;
        halt2 = (ex.valid && ex.is_halt && mem.valid && mem.is_halt) ||
                ((ex.valid && ex.is_halt) && wb_halt) || ((mem.valid && mem.is_halt) && wb_halt);
        go    = adv && state == RUN && (redir || !lu);
        state_nxt = (issue && hz.id_is_halt) ? DRAIN :
                    (adv && state == DRAIN && wb_halt) ? DONE : state;
    end

    assign hz.pc_en       = go;
    assign hz.ifid_en     = go;
    assign hz.idex_bubble = adv && !redir && (lu || state != RUN);
    assign hz.flush_ifid  = redir;
    assign hz.flush_idex  = redir && SQUASH_N == 2;
    assign hz.fwd_a       = fwd_a_q;
    assign hz.fwd_b       = fwd_b_q;
    assign hz.halt_done   = state == DONE;
    assign hz.err         = err_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= RUN;
        else      state <= state_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex      <= '0;
            mem     <= '0;
            ex_load <= 1'b0;
            wb_halt <= 1'b0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
            pend    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pend  <= !adv && (pend || hz.redirect);
            err_q <= err_q || SQ_BAD || (hz.redirect && state != RUN) || halt2;
            if (adv) begin
                mem     <= ex;
                wb_halt <= mem.valid && mem.is_halt;
                ex      <= issue ? slot_t'({1'b1, hz.id_rd_en, hz.id_rd, hz.id_is_halt}) : '0;
                ex_load <= issue && hz.id_is_load;
                fwd_a_q <= issue ? fwd_sel(hz.id_rs_en, hz.id_rs, ex, mem) : 2'b00;
                fwd_b_q <= issue ? fwd_sel(hz.id_rt_en, hz.id_rt, ex, mem) : 2'b00;
            end
        end
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard, forwarding and pipeline-sequencing controller for the 5-stage pipelined successor of the single-cycle processor (IF/ID/EX/MEM/WB). It tracks the destination register of every in-flight instruction in EX, MEM and WB. From that state it generates stall, bubble, flush and registered forwarding selects, freezes the pipe on data-memory busy, and drains the pipe on HALT. It sits beside the decode stage and is parametrised on register-address width and on branch-redirect squash depth.

Parameters:
REG_AW, 3, register specifier width (8 GPRs; no hard-wired zero register)
SQUASH_N, 2, younger pipeline slots killed on redirect (legal 1..2; 1 = IF/ID only, 2 = IF/ID and ID/EX)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
id_valid  in  1  ID stage holds a real instruction
id_rs_en  in  1  ID reads rs
id_rs  in  REG_AW  ID source A
id_rt_en  in  1  ID reads rt
id_rt  in  REG_AW  ID source B
id_rd_en  in  1  ID writes a register
id_rd  in  REG_AW  ID destination
id_is_load  in  1  ID instruction is LD
id_is_halt  in  1  ID instruction is HALT
redirect  in  1  EX resolved a taken branch or jump this cycle
mem_busy  in  1  data memory not ready; whole pipe must hold
pc_en  out  1  PC register write enable
ifid_en  out  1  IF/ID register write enable
idex_bubble  out  1  load NOP into ID/EX instead of the ID instruction
flush_ifid  out  1  invalidate IF/ID
flush_idex  out  1  invalidate ID/EX
fwd_a  out  2  registered EX operand-A select: 00 register file, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  same for operand B
halt_done  out  1  HALT has retired from WB
err  out  1  sticky illegal-condition flag

Behaviour:
- Scoreboard: three slots (EX, MEM, WB), each holding {valid, rd_en, rd, is_load, is_halt}. Reset clears all.
- adv = !mem_busy. If adv=0, all slots, fwd_a/fwd_b and the FSM hold; pc_en=ifid_en=0; idex_bubble, flush_ifid and flush_idex are 0.
- On an adv cycle, slots shift EX->MEM->WB. EX loads the ID fields when an ID instruction issues; otherwise EX.valid=0.
- Load-use stall: EX.valid & EX.is_load & EX.rd_en & id_valid, with (id_rs_en & id_rs==EX.rd) or (id_rt_en & id_rt==EX.rd). Response: pc_en=0, ifid_en=0, idex_bubble=1 for exactly one adv cycle.
- Forwarding, registered on the issue edge so the value applies while the instruction is in EX. For each operand, priority is:
  - 01 if the current EX slot (moving to MEM) matches with valid & rd_en;
  - else 10 if the current MEM slot matches;
  - else 00.
  - WB matches return 00; the register file writes through.
  - fwd_x=00 whenever that operand is not enabled or a bubble is issued.
- Redirect, when adv:
  - flush_ifid=1; flush_idex=1 when SQUASH_N=2.
  - The killed ID instruction does not enter EX (EX.valid=0).
  - Redirect has priority over load-use stall.
  - pc_en=1 so the target loads.
- redirect while mem_busy: a pending bit is set. Flush is applied on the first adv cycle, with no need for redirect to still be high. Pending clears on that cycle and on reset.
- FSM states:
  - RUN: normal operation.
  - DRAIN: entered when an instruction with id_is_halt issues to EX. pc_en=0 and ifid_en=0; id_valid is ignored and bubbles are issued.
  - DONE: entered on the adv cycle where the halt slot leaves WB. halt_done=1 and held; pc_en=0.
  - Only reset leaves DONE.
- err, sticky until reset, set on any of:
  - redirect while FSM != RUN;
  - two slots with is_halt;
  - SQUASH_N outside 1..2 (checked at elaboration or at first clock).
- Reset values: pc_en=1, ifid_en=1, idex_bubble=0, flush_ifid=0, flush_idex=0, fwd_a=fwd_b=00, halt_done=0, err=0, FSM=RUN. The combinational outputs follow the cleared state.
- Reset asserted mid-DRAIN or with a redirect pending returns everything to the reset values immediately (asynchronous).

Test Plan:
- Load-use: LD r2 in EX, ID "ADD r3,r2,r1" (rs=2) -> one cycle with pc_en=0, ifid_en=0, idex_bubble=1. The next issue has fwd_a=10.
- Forward priority: EX.rd=4, MEM.rd=4, ID rs=4 and rt=4 -> fwd_a=fwd_b=01 on issue. With EX.rd_en=0 -> both 10. With neither slot matching -> 00.
- Redirect while mem_busy=1 for 3 cycles -> no flush and all enables 0. First cycle after mem_busy=0 -> flush_ifid=1 and flush_idex=1 (SQUASH_N=2). Repeat with SQUASH_N=1 -> flush_idex=0.
- Redirect and load-use in the same cycle -> flush_ifid=1, idex_bubble=0, pc_en=1.
- HALT issues with two older instructions in flight -> pc_en=0 from the next cycle. halt_done rises on the adv cycle HALT leaves WB and stays 1. A redirect afterwards -> err=1.
- Async reset (rst=0) mid-DRAIN, asserted between clock edges -> all outputs return to reset values before the next edge. Re-release runs normal issue.
